// File: rtl/alu32_bist.sv
// Built-in self-test sequencer for the 32-bit 74181-style alu32: drives LFSR operand
// vectors, waits for the ripple to settle, and checks results against a 33-bit reference.
module alu32_bist #(
  parameter int unsigned NUM_VECTORS   = 256,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [31:0] SEED_A        = 32'hACE1_2468,
  parameter logic [31:0] SEED_B        = 32'h1357_BDF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_mode,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_index,
  output logic [31:0] fail_result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [3:0]  settle_q, settle_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic        alu_mode_q, alu_mode_d, alu_cin_q, alu_cin_d;
  logic [3:0]  alu_sel_q, alu_sel_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0] err_q, err_d, fail_idx_q, fail_idx_d;
  logic [31:0] fail_res_q, fail_res_d;
  logic [32:0] exp_full;
  logic        cmp_cout;
  logic        mismatch;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Reference is computed from the registered operands, so it is stable during SETTLE/CHECK.
  always_comb begin
    exp_full = '0;
    cmp_cout = 1'b0;
    case (op_q)
      3'd0: begin
        exp_full = {1'b0, alu_a_q} + {1'b0, alu_b_q} + {32'd0, alu_cin_q};
        cmp_cout = 1'b1;
      end
      3'd1: begin
        exp_full = {1'b0, alu_a_q} + {1'b0, ~alu_b_q} + {32'd0, alu_cin_q};
        cmp_cout = 1'b1;
      end
      3'd2:    exp_full = {1'b0, alu_a_q ^ alu_b_q};
      3'd3:    exp_full = {1'b0, alu_a_q & alu_b_q};
      3'd4:    exp_full = {1'b0, alu_a_q | alu_b_q};
      default: exp_full = {1'b0, ~alu_a_q};
    endcase
    mismatch = (alu_result != exp_full[31:0]) || (cmp_cout && (alu_cout != exp_full[32]));
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    settle_d   = settle_q;
    op_d       = op_q;
    lfsr_a_d   = lfsr_a_q;
    lfsr_b_d   = lfsr_b_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    alu_sel_d  = alu_sel_q;
    alu_cin_d  = alu_cin_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    fail_res_d = fail_res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = DRIVE;
          index_d    = '0;
          op_d       = '0;
          err_d      = '0;
          fail_idx_d = '0;
          fail_res_d = '0;
          pass_d     = 1'b0;
          lfsr_a_d   = SEED_A;
          lfsr_b_d   = SEED_B;
        end
      end
      DRIVE: begin
        alu_a_d   = lfsr_a_q;
        alu_b_d   = lfsr_b_q;
        alu_cin_d = lfsr_a_q[0] ^ lfsr_b_q[0];
        case (op_q)
          3'd0:    begin alu_mode_d = 1'b0; alu_sel_d = 4'b1001; end
          3'd1:    begin alu_mode_d = 1'b0; alu_sel_d = 4'b0110; end
          3'd2:    begin alu_mode_d = 1'b1; alu_sel_d = 4'b0110; end
          3'd3:    begin alu_mode_d = 1'b1; alu_sel_d = 4'b1011; end
          3'd4:    begin alu_mode_d = 1'b1; alu_sel_d = 4'b1110; end
          default: begin alu_mode_d = 1'b1; alu_sel_d = 4'b0000; end
        endcase
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) state_d = CHECK;
        else                                   settle_d = settle_q + 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          // A saturating count never returns to zero, so zero marks "no failure seen yet".
          if (err_q == 16'd0) begin
            fail_idx_d = index_q;
            fail_res_d = alu_result;
          end
        end
        if (index_q < 16'(NUM_VECTORS - 1)) begin
          index_d = index_q + 16'd1;
          op_d    = (op_q == 3'd5) ? 3'd0 : op_q + 3'd1;
          state_d = DRIVE;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        pass_d  = (err_q == 16'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      settle_q   <= '0;
      op_q       <= '0;
      lfsr_a_q   <= SEED_A;
      lfsr_b_q   <= SEED_B;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= 1'b0;
      alu_sel_q  <= '0;
      alu_cin_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_idx_q <= '0;
      fail_res_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      settle_q   <= settle_d;
      op_q       <= op_d;
      lfsr_a_q   <= lfsr_a_d;
      lfsr_b_q   <= lfsr_b_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      alu_sel_q  <= alu_sel_d;
      alu_cin_q  <= alu_cin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      fail_res_q <= fail_res_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_mode    = alu_mode_q;
  assign alu_sel     = alu_sel_q;
  assign alu_cin     = alu_cin_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_index  = fail_idx_q;
  assign fail_result = fail_res_q;

endmodule

// File: tb/tb_alu32_bist.sv
// Directed bench for alu32_bist: golden, seed-corner, stuck-bit and bad-carry alu32 models
// each drive a separate instance; expected values are hand-derived constants.
module tb_alu32_bist;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Behavioural alu32, keyed on the 74181 mode/select pins.
  function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic m, input logic [3:0] s, input logic c);
    logic [32:0] r;
    r = '0;
    case ({m, s})
      5'b0_1001: r = {1'b0, a} + {1'b0, b} + {32'd0, c};
      5'b0_0110: r = {1'b0, a} + {1'b0, ~b} + {32'd0, c};
      5'b1_0110: r = {1'b0, a ^ b};
      5'b1_1011: r = {1'b0, a & b};
      5'b1_1110: r = {1'b0, a | b};
      5'b1_0000: r = {1'b0, ~a};
      default:   r = '0;
    endcase
    return r;
  endfunction

  // d_ golden, s_ seed corner, f_ result[0] stuck-at-0, c_ wrong carry on op 1
  logic        d_start = 1'b0, s_start = 1'b0, f_start = 1'b0, c_start = 1'b0;
  logic [31:0] d_a, d_b, d_res, s_a, s_b, s_res, f_a, f_b, f_res, c_a, c_b, c_res;
  logic        d_mode, d_cin, d_cout, s_mode, s_cin, s_cout, f_mode, f_cin, f_cout;
  logic        c_mode, c_cin, c_cout;
  logic [3:0]  d_sel, s_sel, f_sel, c_sel;
  logic        d_busy, d_done, d_pass, s_busy, s_done, s_pass;
  logic        f_busy, f_done, f_pass, c_busy, c_done, c_pass;
  logic [15:0] d_err, d_fidx, s_err, s_fidx, f_err, f_fidx, c_err, c_fidx;
  logic [31:0] d_fres, s_fres, f_fres, c_fres;
  logic [32:0] d_gold, s_gold, f_gold, c_gold;

  always_comb begin
    d_gold = golden(d_a, d_b, d_mode, d_sel, d_cin);
    s_gold = golden(s_a, s_b, s_mode, s_sel, s_cin);
    f_gold = golden(f_a, f_b, f_mode, f_sel, f_cin);
    c_gold = golden(c_a, c_b, c_mode, c_sel, c_cin);
  end

  assign d_res  = d_gold[31:0];
  assign d_cout = d_gold[32];
  assign s_res  = s_gold[31:0];
  assign s_cout = s_gold[32];
  assign f_res  = {f_gold[31:1], 1'b0};
  assign f_cout = f_gold[32];
  assign c_res  = c_gold[31:0];
  // Carry inverted for subtract, and forced high for logic ops where it must be ignored.
  assign c_cout = (!c_mode && c_sel == 4'b0110) ? ~c_gold[32] : (c_mode ? 1'b1 : c_gold[32]);

  alu32_bist #(.NUM_VECTORS(6), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(d_start), .alu_a(d_a), .alu_b(d_b), .alu_mode(d_mode),
    .alu_sel(d_sel), .alu_cin(d_cin), .alu_result(d_res), .alu_cout(d_cout), .busy(d_busy),
    .done(d_done), .pass(d_pass), .err_count(d_err), .fail_index(d_fidx), .fail_result(d_fres));

  alu32_bist #(.NUM_VECTORS(6), .SETTLE_CYCLES(2), .SEED_A(32'hFFFF_FFFF), .SEED_B(32'h0000_0001)) u_seed (
    .clk(clk), .rst(rst), .start(s_start), .alu_a(s_a), .alu_b(s_b), .alu_mode(s_mode),
    .alu_sel(s_sel), .alu_cin(s_cin), .alu_result(s_res), .alu_cout(s_cout), .busy(s_busy),
    .done(s_done), .pass(s_pass), .err_count(s_err), .fail_index(s_fidx), .fail_result(s_fres));

  alu32_bist #(.NUM_VECTORS(256), .SETTLE_CYCLES(2)) u_fault (
    .clk(clk), .rst(rst), .start(f_start), .alu_a(f_a), .alu_b(f_b), .alu_mode(f_mode),
    .alu_sel(f_sel), .alu_cin(f_cin), .alu_result(f_res), .alu_cout(f_cout), .busy(f_busy),
    .done(f_done), .pass(f_pass), .err_count(f_err), .fail_index(f_fidx), .fail_result(f_fres));

  alu32_bist #(.NUM_VECTORS(12), .SETTLE_CYCLES(2)) u_cout (
    .clk(clk), .rst(rst), .start(c_start), .alu_a(c_a), .alu_b(c_b), .alu_mode(c_mode),
    .alu_sel(c_sel), .alu_cin(c_cin), .alu_result(c_res), .alu_cout(c_cout), .busy(c_busy),
    .done(c_done), .pass(c_pass), .err_count(c_err), .fail_index(c_fidx), .fail_result(c_fres));

  // Default-seed vectors 0..3 and the {mode,sel} for ops 0..5.
  logic [31:0] exp_a   [4] = '{32'hACE1_2468, 32'h5670_9234, 32'h2B38_491A, 32'h159C_248D};
  logic [31:0] exp_b   [4] = '{32'h1357_BDF0, 32'h09AB_DEF8, 32'h04D5_EF7C, 32'h026A_F7BE};
  logic        exp_cin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [4:0]  exp_op  [6] = '{5'h09, 5'h06, 5'h16, 5'h1B, 5'h1E, 5'h10};

  // Start is sampled on the edge after this task raises it; the next negedge is cycle 1.
  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      0: d_start = 1'b1;
      1: s_start = 1'b1;
      2: f_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    d_start = 1'b0;
    s_start = 1'b0;
    f_start = 1'b0;
    c_start = 1'b0;
  endtask

  task automatic run_to_done(input int which, input int budget, output int cyc);
    logic dn;
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      case (which)
        0: dn = d_done;
        1: dn = s_done;
        2: dn = f_done;
        default: dn = c_done;
      endcase
      if (dn) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic seen;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(d_busy), 32'd0);
    check_val("rst_done", 32'(d_done), 32'd0);
    check_val("rst_a", d_a, 32'd0);
    check_val("rst_err", 32'(d_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Golden run with a stray start during SETTLE and start held into FINISH
    pulse_start(0);
    cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      int k;
      int ph;
      @(negedge clk);
      k  = (c - 1) / 4;
      ph = (c - 1) % 4;
      d_start = (c == 6);
      if (k < 6 && ph == 1) begin
        check_val($sformatf("op_k%0d", k), 32'({d_mode, d_sel}), 32'(exp_op[k]));
        if (k < 4) begin
          check_val($sformatf("a_k%0d", k), d_a, exp_a[k]);
          check_val($sformatf("b_k%0d", k), d_b, exp_b[k]);
          check_val($sformatf("cin_k%0d", k), 32'(d_cin), 32'(exp_cin[k]));
        end
      end
      if (k < 4 && ph == 3) check_val($sformatf("a_hold_k%0d", k), d_a, exp_a[k]);
      if (c == 24) check_val("busy_last_check", 32'(d_busy), 32'd1);
      if (d_done) begin
        cyc = c;
        break;
      end
    end
    check_val("run_len", 32'(cyc), 32'd25);
    d_start = 1'b1;
    check_val("busy_finish", 32'(d_busy), 32'd0);
    @(negedge clk);
    d_start = 1'b0;
    check_val("pass", 32'(d_pass), 32'd1);
    check_val("err_count", 32'(d_err), 32'd0);
    check_val("done_pulse_end", 32'(d_done), 32'd0);
    check_val("no_restart_1", 32'(d_busy), 32'd0);
    @(negedge clk);
    check_val("no_restart_2", 32'(d_busy), 32'd0);

    // Abort at vector 3 with an asynchronous reset between edges
    pulse_start(0);
    for (int c = 1; c <= 14; c++) @(negedge clk);
    check_val("busy_v3", 32'(d_busy), 32'd1);
    check_val("a_v3", d_a, 32'h159C_248D);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", 32'(d_busy), 32'd0);
    check_val("arst_a", d_a, 32'd0);
    check_val("arst_b", d_b, 32'd0);
    check_val("arst_modesel", 32'({d_mode, d_sel, d_cin}), 32'd0);
    check_val("arst_pass", 32'(d_pass), 32'd0);
    check_val("arst_fail", d_fres | 32'(d_fidx) | 32'(d_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (d_done || d_busy) seen = 1'b1;
    end
    check_val("abort_quiet", 32'(seen), 32'd0);
    pulse_start(0);
    run_to_done(0, 40, cyc);
    check_val("rerun_len", 32'(cyc), 32'd25);
    @(negedge clk);
    check_val("rerun_pass", 32'(d_pass), 32'd1);

    // Seed corner: all-ones plus one carries out with a zero result
    pulse_start(1);
    @(negedge clk);
    @(negedge clk);
    check_val("s_a0", s_a, 32'hFFFF_FFFF);
    check_val("s_b0", s_b, 32'h0000_0001);
    check_val("s_cin0", 32'(s_cin), 32'd0);
    check_val("s_op0", 32'({s_mode, s_sel}), 32'h09);
    run_to_done(1, 40, cyc);
    check_val("s_run_len", 32'(cyc), 32'd23);
    @(negedge clk);
    check_val("s_err", 32'(s_err), 32'd0);
    check_val("s_pass", 32'(s_pass), 32'd1);

    // Result bit 0 stuck at 0: first expected odd result is vector 1 (subtract)
    pulse_start(2);
    run_to_done(2, 1100, cyc);
    check_val("f_run_len", 32'(cyc), 32'd1025);
    @(negedge clk);
    check_val("f_pass", 32'(f_pass), 32'd0);
    check_val("f_err_nonzero", 32'(f_err != 16'd0), 32'd1);
    check_val("f_fail_index", 32'(f_fidx), 32'd1);
    check_val("f_fail_result", f_fres, 32'h4CC4_B33A);

    // Wrong carry on subtract only: vectors 1 and 7 fail, logic ops ignore carry
    pulse_start(3);
    run_to_done(3, 60, cyc);
    check_val("c_run_len", 32'(cyc), 32'd49);
    @(negedge clk);
    check_val("c_err", 32'(c_err), 32'd2);
    check_val("c_fail_index", 32'(c_fidx), 32'd1);
    check_val("c_fail_result", c_fres, 32'h4CC4_B33B);
    check_val("c_pass", 32'(c_pass), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
